// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register map (by data_address[3:2]):
//   0 TXDATA (WO), 1 STATUS, 2 BAUDDIV, 3 CTRL.
// Build option: define IVM_UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8-E-1 framing).
module mmio_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [31:0] data_address,
    input  logic [31:0] data_store,
    input  logic        data_read,
    input  logic        data_enable,
    output logic [31:0] data_fetch,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

`ifdef IVM_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Bus decode
    logic        wr;
    logic        rd;
    logic        wr_txdata;
    logic        wr_status;
    logic        wr_div;
    logic        wr_ctrl;

    // Control/status registers
    logic [15:0] div_reg;
    logic        tx_en_reg;
    logic        irq_en_reg;
    logic        ovf_reg;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Transmitter
    state_t      state_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt_reg;
    logic [15:0] baud_cnt_reg;
    logic        tx_reg;
    logic        busy;
    logic        bit_end;
`ifdef IVM_UART_TX_PARITY_EN
    logic        parity_reg;
`endif

    logic [31:0] rd_data;
    logic [31:0] fetch_reg;
    logic        irq_reg;

    // Address bits outside [3:2] and write data above bit 15 are don't-care.
    logic unused_bits;
    assign unused_bits = ^{data_address[31:4], data_address[1:0], data_store[31:16]};

    assign wr        = sel & data_enable & ~data_read;
    assign rd        = sel & data_enable & data_read;
    assign wr_txdata = wr & (data_address[3:2] == 2'd0);
    assign wr_status = wr & (data_address[3:2] == 2'd1);
    assign wr_div    = wr & (data_address[3:2] == 2'd2);
    assign wr_ctrl   = wr & (data_address[3:2] == 2'd3);

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign busy    = (state_reg != IDLE);
    assign bit_end = (baud_cnt_reg == 16'd0);
    // The FSM only pulls a byte while idle, so a pop can never hit an empty FIFO.
    assign pop     = (state_reg == IDLE) & tx_en_reg & ~empty;
    // A write to a full FIFO still fits if a byte leaves in the same cycle.
    assign push    = wr_txdata & (~full | pop);

    // Configuration registers and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg    <= 16'(DIV_RESET);
            tx_en_reg  <= 1'b1;
            irq_en_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_div) div_reg <= data_store[15:0];
            if (wr_ctrl) begin
                tx_en_reg  <= data_store[0];
                irq_en_reg <= data_store[1];
            end
            if (wr_txdata & full & ~pop)
                ovf_reg <= 1'b1;
            else if (wr_status & data_store[3])
                ovf_reg <= 1'b0;
        end
    end

    // FIFO storage: written on push, no reset needed for the payload
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= data_store[7:0];
    end

    // FIFO pointers and occupancy count; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push & ~pop)
                count_reg <= count_reg + CW'(1);
            else if (pop & ~push)
                count_reg <= count_reg - CW'(1);
        end
    end

    // Transmit FSM: one baud counter times every bit, reloaded from BAUDDIV at each bit end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            baud_cnt_reg <= 16'd0;
            tx_reg       <= 1'b1;
`ifdef IVM_UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            if (state_reg != IDLE)
                baud_cnt_reg <= bit_end ? div_reg : baud_cnt_reg - 16'd1;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        shift_reg    <= mem[rd_ptr_reg];
`ifdef IVM_UART_TX_PARITY_EN
                        parity_reg   <= ^mem[rd_ptr_reg];
`endif
                        bit_cnt_reg  <= 3'd0;
                        baud_cnt_reg <= div_reg;
                        tx_reg       <= 1'b0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_reg == 3'd7) begin
`ifdef IVM_UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
`endif
                        end else begin
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
`ifdef IVM_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_reg    <= 1'b1;
                        state_reg <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        tx_reg    <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read mux for the selected register
    always_comb begin
        rd_data = 32'h0;
        case (data_address[3:2])
            2'd1:    rd_data = {16'h0, 8'(count_reg), 4'h0, ovf_reg, busy, full, empty};
            2'd2:    rd_data = {16'h0, div_reg};
            2'd3:    rd_data = {30'h0, irq_en_reg, tx_en_reg};
            default: rd_data = 32'h0;
        endcase
    end

    // Registered read data (zero when not reading) and level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_reg <= 32'h0;
            irq_reg   <= 1'b0;
        end else begin
            fetch_reg <= rd ? rd_data : 32'h0;
            irq_reg   <= irq_en_reg & empty & ~busy;
        end
    end

    assign data_fetch = fetch_reg;
    assign uart_tx    = tx_reg;
    assign irq        = irq_reg;

endmodule
